// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional byte-strobe support is selected with DMEM_BYTE_STROBE_EN.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        TURN = 2'd3
    } state_e;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;
    localparam int unsigned CNT_W          = 4;

    // Bit positions of the individual fault causes in a cause vector
    localparam int unsigned MISALIGN   = 0;
    localparam int unsigned RANGE      = 1;
    localparam int unsigned CONFLICT   = 2;
    localparam int unsigned NUM_CAUSES = 3;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    function automatic logic misaligned(input req_t r);
`ifdef DMEM_BYTE_STROBE_EN
        if (!r.wr) begin
            return r.addr[1:0] != 2'b00;
        end
        case (r.strb)
            4'b1111:                            return r.addr[1:0] != 2'b00;
            4'b0011, 4'b1100:                   return r.addr[0];
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b0;
            default:                            return 1'b1;
        endcase
`else
        return r.addr[1:0] != 2'b00;
`endif
    endfunction

    // Widened to 33 bits so a window ending at the top of the address space still compares correctly
    function automatic logic out_of_range(input logic [31:0] a, input logic [31:0] base,
                                          input int unsigned depth);
        logic [32:0] lo_b;
        logic [32:0] hi_b;
        lo_b = {1'b0, base};
        hi_b = lo_b + (33'(depth) << 2);
        return ({1'b0, a} < lo_b) || ({1'b0, a} >= hi_b);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM: synchronous write with per-byte enables, combinational read.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [3:0]                     be_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rd_word_c
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rd_word_c = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the multicycle core: fixed wait states, one-cycle ready, fault flagging.
// Define DMEM_BYTE_STROBE_EN to add the wstrb byte-lane store input.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  wstrb,
`endif
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_e                 state_q;
    req_t                   req_q;
    req_t                   req_c;
    logic [CNT_W-1:0]       cnt_q;
    logic [31:0]            rdata_q;
    logic                   ready_q;
    logic                   err_q;
    logic                   busy_q;
    logic [NUM_CAUSES-1:0]  cause_c;
    logic                   fault_c;
    logic                   access_c;
    logic                   ram_we_c;
    logic [AW-1:0]          word_idx_c;
    logic [31:0]            rd_word_c;

    // Incoming request as it would be latched in IDLE
    always_comb begin
        req_c.rd    = mem_read;
        req_c.wr    = mem_write;
        req_c.addr  = addr;
        req_c.wdata = wdata;
`ifdef DMEM_BYTE_STROBE_EN
        req_c.strb  = wstrb;
`else
        req_c.strb  = 4'hF;
`endif
    end

    // Fault causes are judged on the latched request only
    always_comb begin
        cause_c           = '0;
        cause_c[MISALIGN] = misaligned(req_q);
        cause_c[RANGE]    = out_of_range(req_q.addr, BASE_ADDR, DEPTH_WORDS);
        cause_c[CONFLICT] = req_q.rd & req_q.wr;
    end

    assign fault_c    = |cause_c;
    assign access_c   = (state_q == WAIT) && (cnt_q == '0);
    assign ram_we_c   = access_c && req_q.wr && !fault_c;
    assign word_idx_c = AW'((req_q.addr - BASE_ADDR) >> 2);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk       (clk),
        .we_i      (ram_we_c),
        .idx_i     (word_idx_c),
        .be_i      (req_q.strb),
        .wdata_i   (req_q.wdata),
        .rd_word_c (rd_word_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        req_q   <= req_c;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        rdata_q <= (req_q.rd && !fault_c) ? rd_word_c : 32'h0;
                        err_q   <= fault_c;
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    ready_q <= 1'b0;
                    state_q <= TURN;
                end
                TURN: begin
                    // Dead cycle: a request still held from the last access is ignored here
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; directed cases plus randomized traffic against a memory model.
// Define DMEM_BYTE_STROBE_EN to exercise the byte-strobe variant.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  wstrb;
`endif
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    dmem_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .wstrb     (wstrb),
`endif
        .rdata     (rdata),
        .ready     (ready),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          err;
        bit          chk_data;
        bit [31:0]   data;
        int unsigned cyc;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    bit [31:0]   model_mem [int unsigned];
    int          errors = 0;
    int          checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst === 1'b0 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 expected no pending request (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check32({mon_e.name, "_err"}, 32'(err), 32'(mon_e.err));
                check32({mon_e.name, "_latency"}, cyc, mon_e.cyc);
                if (mon_e.err || mon_e.chk_data) begin
                    check32({mon_e.name, "_rdata"}, rdata, mon_e.data);
                end
            end
        end
    end

    // Builds the expectation from the memory rules, updates the model, then drives until ready
    task automatic issue(input string name, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input bit scramble);
        exp_t        e;
        bit          ferr;
        bit          got;
        longint      la;
        int unsigned idx;
        logic [3:0]  s_eff;
        bit [31:0]   w;
        @(posedge clk);
        #1;
        la = longint'(a);
`ifdef DMEM_BYTE_STROBE_EN
        s_eff = s;
`else
        s_eff = 4'hF;
`endif
        ferr = rd && wr;
        if (la < longint'(BASE) || la >= longint'(BASE) + 4 * longint'(DEPTH)) ferr = 1'b1;
        if (wr && !rd) begin
            case ($countones(s_eff))
                4:       if (la % 4 != 0) ferr = 1'b1;
                2:       if (!(s_eff == 4'b0011 || s_eff == 4'b1100) || la % 2 != 0) ferr = 1'b1;
                1:       ;
                default: ferr = 1'b1;
            endcase
        end else if (la % 4 != 0) begin
            ferr = 1'b1;
        end
        idx        = (a - BASE) >> 2;
        e.err      = ferr;
        e.name     = name;
        e.cyc      = cyc + 1 + LAT;
        e.chk_data = rd;
        e.data     = 32'h0;
        if (!ferr && rd) begin
            if (model_mem.exists(idx)) e.data = model_mem[idx];
            else e.chk_data = 1'b0;
        end
        if (!ferr && wr) begin
            if (model_mem.exists(idx) || s_eff == 4'hF) begin
                w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
                for (int b = 0; b < 4; b++) if (s_eff[b]) w[8*b +: 8] = d[8*b +: 8];
                model_mem[idx] = w;
            end
        end
        exp_q.push_back(e);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
`ifdef DMEM_BYTE_STROBE_EN
        wstrb     = s;
`endif
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (ready === 1'b1) got = 1'b1;
            else if (scramble && n >= 1) begin
                addr  = $urandom;
                wdata = $urandom;
`ifdef DMEM_BYTE_STROBE_EN
                wstrb = 4'($urandom);
`endif
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ready expected ready within 40 cycles", name);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic count_ready(input int unsigned ncyc, output int unsigned cnt);
        cnt = 0;
        for (int unsigned n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (ready === 1'b1) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rc;
        int unsigned r;
        int unsigned m;
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [3:0]  s;
        logic [3:0]  strb_tab [10];
        strb_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'h0, 4'h6};

        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
`ifdef DMEM_BYTE_STROBE_EN
        wstrb     = 4'h0;
`endif
        repeat (3) @(negedge clk);
        check32("reset_ready", 32'(ready), 32'h0);
        check32("reset_err", 32'(err), 32'h0);
        check32("reset_busy", 32'(busy), 32'h0);
        check32("reset_rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue("st_deadbeef", 1'b0, 1'b1, BASE + 32'h4, 32'hDEADBEEF, 4'hF, 1'b0);
        issue("ld_deadbeef", 1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b0);
        issue("st_word0", 1'b0, 1'b1, BASE, 32'h55AA_0000, 4'hF, 1'b0);
        issue("ld_misalign", 1'b1, 1'b0, BASE + 32'h2, 32'h0, 4'hF, 1'b0);
        issue("ld_word0", 1'b1, 1'b0, BASE, 32'h0, 4'hF, 1'b0);
        issue("st_past_end", 1'b0, 1'b1, BASE + 32'h1000, 32'h0BAD_0BAD, 4'hF, 1'b0);
        issue("st_top", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0BAD_0BAD, 4'hF, 1'b0);
        issue("ld_below", 1'b1, 1'b0, BASE - 32'h4, 32'h0, 4'hF, 1'b0);
        issue("st_last", 1'b0, 1'b1, BASE + 32'hFFC, 32'h7777_1111, 4'hF, 1'b0);
        issue("ld_last", 1'b1, 1'b0, BASE + 32'hFFC, 32'h0, 4'hF, 1'b0);
        issue("ld_word0_again", 1'b1, 1'b0, BASE, 32'h0, 4'hF, 1'b0);

        // Conflicting request held through the turnaround cycle must be served once
        begin
            exp_t e;
            bit   got;
            @(posedge clk);
            #1;
            e.err = 1'b1; e.chk_data = 1'b1; e.data = 32'h0; e.cyc = cyc + 1 + LAT; e.name = "conflict";
            exp_q.push_back(e);
            mem_read  = 1'b1;
            mem_write = 1'b1;
            addr      = BASE;
            wdata     = 32'hFFFF_FFFF;
            got = 1'b0;
            for (int n = 0; n < 40 && !got; n++) begin
                @(negedge clk);
                if (ready === 1'b1) got = 1'b1;
            end
            check32("conflict_ready_seen", 32'(got), 32'h1);
            @(posedge clk);
            #1;
            check32("conflict_busy_turn", 32'(busy), 32'h1);
            check32("conflict_ready_turn", 32'(ready), 32'h0);
            @(posedge clk);
            #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            count_ready(8, rc);
            check32("conflict_single_ready", rc, 32'h0);
        end

        // Reset during WAIT discards the pending store
        issue("st_cafe", 1'b0, 1'b1, BASE + 32'h8, 32'hCAFE_F00D, 4'hF, 1'b0);
        @(posedge clk);
        #1;
        mem_write = 1'b1;
        addr      = BASE + 32'h8;
        wdata     = 32'h1234_5678;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        mem_write = 1'b0;
        #1;
        check32("midrst_busy", 32'(busy), 32'h0);
        check32("midrst_ready", 32'(ready), 32'h0);
        check32("midrst_rdata", rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_ready(6, rc);
        check32("midrst_no_ready", rc, 32'h0);
        issue("ld_after_rst", 1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'hF, 1'b0);

`ifdef DMEM_BYTE_STROBE_EN
        issue("st_11223344", 1'b0, 1'b1, BASE + 32'h10, 32'h1122_3344, 4'hF, 1'b0);
        issue("st_lane1", 1'b0, 1'b1, BASE + 32'h10, 32'hAABB_CCDD, 4'b0010, 1'b0);
        issue("ld_lane1", 1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0);
        check32("lane1_model", model_mem[4], 32'h1122_CC44);
        issue("st_strb_0101", 1'b0, 1'b1, BASE + 32'h10, 32'h0, 4'b0101, 1'b0);
        issue("st_strb_zero", 1'b0, 1'b1, BASE + 32'h10, 32'h0, 4'b0000, 1'b0);
        issue("st_half_hi", 1'b0, 1'b1, BASE + 32'h12, 32'h9988_0000, 4'b1100, 1'b0);
        issue("st_half_odd", 1'b0, 1'b1, BASE + 32'h11, 32'h0, 4'b0011, 1'b0);
        issue("ld_lane_mix", 1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0);
`endif

        for (int i = 0; i < 16; i++) begin
            issue("rnd_preload", 1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 1'b0);
        end
        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 9);
            rd = (r < 4) || (r >= 8);
            wr = (r >= 4) && (r <= 8);
            m  = $urandom_range(0, 9);
            if (m < 7)       a = BASE + 32'(4 * $urandom_range(0, 15));
            else if (m == 7) a = BASE + 32'($urandom_range(0, 63));
            else if (m == 8) a = BASE + 32'(4 * DEPTH - 4 + 4 * $urandom_range(0, 1));
            else             a = $urandom;
            s = (m < 4) ? 4'hF : strb_tab[$urandom_range(0, 9)];
            issue("rnd", rd, wr, a, $urandom, s, 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (10) @(negedge clk);
        check32("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
